// File: rtl/uart_echo_responder.sv
// rtl/uart_echo_responder.sv - far-end UART 8N1 echo responder with oversampled RX, echo FIFO and TX
//
// Receives 8N1 frames on rx with a 16x-oversampled, majority-voted receiver,
// queues good bytes in a small FIFO and retransmits them unchanged on tx.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx         serial input (asynchronous, idles high)
//   echo_en    1 = push good bytes into the echo FIFO
//   tx_pause   1 = hold off starting a new TX frame
//   tx         serial output (registered, idles high)
//   rx_byte    last good received byte
//   rx_valid   1-clk pulse when rx_byte updates
//   frame_err  1-clk pulse on a bad stop bit
//   overflow   1-clk pulse when a good byte is dropped on a full FIFO
//   fifo_count current FIFO occupancy
//   tx_busy    high from FIFO pop until the end of the stop bit

module uart_echo_responder #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  input  logic                        echo_en,
  input  logic                        tx_pause,
  output logic                        tx,
  output logic [7:0]                  rx_byte,
  output logic                        rx_valid,
  output logic                        frame_err,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        tx_busy
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_V0      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1      = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2      = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END     = SW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // Tick generator and input synchronizer
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic          rx_meta_q, rx_sync_q;

  assign tick = (tick_cnt_q == TICK_LAST);

  // Receiver state
  rx_state_e     rx_state_q, rx_state_d;
  logic [SW-1:0] rx_s_q, rx_s_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [1:0]    rx_vote_q, rx_vote_d;      // samples taken at S_V0 and S_V1
  logic          rx_bitval_q, rx_bitval_d;  // voted value held until end of bit
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          rx_good;
  logic          majority;

  // Third vote is the live sample, so majority is only meaningful at S_V2.
  assign majority = (rx_vote_q[0] & rx_vote_q[1]) |
                    (rx_vote_q[0] & rx_sync_q)    |
                    (rx_vote_q[1] & rx_sync_q);

  // FIFO state
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_full, rx_push, do_push, tx_pop;
  logic          overflow_q, overflow_d;

  assign fifo_full  = (count_q == FULL_CNT);
  assign rx_push    = rx_good & echo_en;
  // A pop in the same clock frees the slot, so a full FIFO still accepts.
  assign do_push    = rx_push & (~fifo_full | tx_pop);
  assign overflow_d = rx_push & fifo_full & ~tx_pop;

  // Transmitter state
  tx_state_e     tx_state_q, tx_state_d;
  logic [SW-1:0] tx_s_q, tx_s_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;
  logic          tx_busy_q, tx_busy_d;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_s_d      = rx_s_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_vote_d   = rx_vote_q;
    rx_bitval_d = rx_bitval_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    rx_good     = 1'b0;
    if (tick) begin
      if (rx_s_q == S_V0) rx_vote_d[0] = rx_sync_q;
      if (rx_s_q == S_V1) rx_vote_d[1] = rx_sync_q;
      if (rx_s_q == S_V2) rx_bitval_d  = majority;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_d = RX_START;
            rx_s_d     = '0;
          end
        end
        RX_START: begin
          rx_s_d = rx_s_q + 1'b1;
          if (rx_s_q == S_END) begin
            rx_s_d     = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_bitval_q ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          rx_s_d = rx_s_q + 1'b1;
          if (rx_s_q == S_END) begin
            rx_s_d     = '0;
            rx_shift_d = {rx_bitval_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            else                  rx_bit_d   = rx_bit_q + 1'b1;
          end
        end
        RX_STOP: begin
          rx_s_d = rx_s_q + 1'b1;
          // Decide mid stop bit so a start bit immediately following is not missed.
          if (rx_s_q == S_V2) begin
            if (majority) begin
              rx_byte_d  = rx_shift_q;
              rx_valid_d = 1'b1;
              rx_good    = 1'b1;
              rx_state_d = RX_IDLE;
            end else begin
              frame_err_d = 1'b1;
              rx_state_d  = RX_WAIT_HIGH;
            end
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync_q) rx_state_d = RX_IDLE;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    tx_pop     = 1'b0;
    if (tick) begin
      case (tx_state_q)
        TX_IDLE: begin
          if ((count_q != '0) && !tx_pause) begin
            tx_pop     = 1'b1;
            tx_shift_d = fifo_mem[rd_ptr_q];
            tx_busy_d  = 1'b1;
            tx_d       = 1'b0;
            tx_s_d     = '0;
            tx_state_d = TX_START;
          end
        end
        TX_START: begin
          tx_s_d = tx_s_q + 1'b1;
          if (tx_s_q == S_END) begin
            tx_s_d     = '0;
            tx_bit_d   = '0;
            tx_d       = tx_shift_q[0];
            tx_state_d = TX_DATA;
          end
        end
        TX_DATA: begin
          tx_s_d = tx_s_q + 1'b1;
          if (tx_s_q == S_END) begin
            tx_s_d = '0;
            if (tx_bit_q == 3'd7) begin
              tx_d       = 1'b1;
              tx_state_d = TX_STOP;
            end else begin
              tx_bit_d   = tx_bit_q + 1'b1;
              tx_shift_d = {1'b0, tx_shift_q[7:1]};
              tx_d       = tx_shift_q[1];
            end
          end
        end
        TX_STOP: begin
          tx_s_d = tx_s_q + 1'b1;
          if (tx_s_q == S_END) begin
            tx_s_d     = '0;
            tx_busy_d  = 1'b0;
            tx_state_d = TX_IDLE;
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_s_q      <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_vote_q   <= '0;
      rx_bitval_q <= 1'b0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tx_state_q  <= TX_IDLE;
      tx_s_q      <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
    end else begin
      tick_cnt_q  <= tick ? '0 : tick_cnt_q + 1'b1;
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_s_q      <= rx_s_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_vote_q   <= rx_vote_d;
      rx_bitval_q <= rx_bitval_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (tx_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, tx_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      tx_state_q  <= tx_state_d;
      tx_s_q      <= tx_s_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      tx_busy_q   <= tx_busy_d;
    end
  end

  // Data storage needs no reset; occupancy is governed by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr_q] <= rx_shift_q;
  end

  assign tx         = tx_q;
  assign tx_busy    = tx_busy_q;
  assign rx_byte    = rx_byte_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule
